// File: rtl/fib_rr_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fib_rr_scheduler_pkg
// Description : Shared constants for the round-robin Fibonacci scheduler:
//               FSM state encodings, WAIT_BUSY timeout, default widths.
// Revision    : 1.0 - initial release
// ============================================================================
package fib_rr_scheduler_pkg;

  // Default widths for operand n and result fn
  localparam int DEF_NW = 8;
  localparam int DEF_FW = 32;

  // Cycles allowed in WAIT_BUSY for the engine to raise busy
  localparam int WB_LIMIT = 4;

  // Scheduler FSM encoding
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LAUNCH    = 3'd1;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
  localparam logic [2:0] ST_RUN       = 3'd3;
  localparam logic [2:0] ST_DONE      = 3'd4;

endpackage : fib_rr_scheduler_pkg
`default_nettype wire

// File: rtl/fib_rr_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : fib_rr_scheduler_if
// Description : Client-side request/grant bus and engine start/busy bus of
//               the Fibonacci scheduler. master = scheduler, slave = the
//               clients plus the engine seen as one environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface fib_rr_scheduler_if
  import fib_rr_scheduler_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int NW   = DEF_NW,
  parameter int FW   = DEF_FW
);

  // client side
  logic [NREQ-1:0]    req;
  logic [NREQ*NW-1:0] req_n;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic [FW-1:0]      result;
  logic               err;

  // engine side
  logic [NW-1:0]      eng_n;
  logic               eng_st;
  logic               eng_busy;
  logic [FW-1:0]      eng_fn;

  modport master (
    input  req, req_n, eng_busy, eng_fn,
    output gnt, done, result, err, eng_n, eng_st
  );

  modport slave (
    output req, req_n, eng_busy, eng_fn,
    input  gnt, done, result, err, eng_n, eng_st
  );

endinterface : fib_rr_scheduler_if
`default_nettype wire

// File: rtl/fib_rr_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick. Returns the first active
//               request at or after ptr (wrapping) as one-hot and as index.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  wire logic [NREQ-1:0] req,
  input  wire logic [PW-1:0]   ptr,
  output logic      [NREQ-1:0] gnt_oh,
  output logic      [PW-1:0]   idx,
  output logic                 valid
);

  // Scan NREQ positions starting at ptr; the first hit wins
  always_comb begin
    int          j;
    logic [PW-1:0] jj;
    gnt_oh = '0;
    idx    = '0;
    valid  = 1'b0;
    j      = 0;
    jj     = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) begin
        j = j - NREQ;
      end
      jj = PW'(j);
      if (!valid && req[jj]) begin
        valid      = 1'b1;
        gnt_oh[jj] = 1'b1;
        idx        = jj;
      end
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/fib_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : fib_rr_scheduler
// Description : Shares one iterative Fibonacci engine among NREQ clients.
//               Round-robin grant, engine start/busy sequencing with
//               WAIT_BUSY and RUN watchdogs, result capture and a one-cycle
//               done (and err on abort) pulse to the owner.
// Revision    : 1.0 - initial release
// ============================================================================
module fib_rr_scheduler
  import fib_rr_scheduler_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int NW   = DEF_NW,
  parameter int FW   = DEF_FW,
  parameter int TMO  = 512
) (
  input  wire logic          clk,
  input  wire logic          rst,
  fib_rr_scheduler_if.master bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WW = $clog2(TMO + 1);

  logic [2:0]      state_q,   state_d;
  logic [PW-1:0]   owner_q,   owner_d;
  logic [PW-1:0]   ptr_q,     ptr_d;
  logic [NREQ-1:0] gnt_q,     gnt_d;
  logic [NREQ-1:0] done_q,    done_d;
  logic [FW-1:0]   result_q,  result_d;
  logic            err_q,     err_d;
  logic [NW-1:0]   eng_n_q,   eng_n_d;
  logic            eng_st_q,  eng_st_d;
  logic [WW-1:0]   wd_q,      wd_d;

  logic [NREQ-1:0] pick_oh;
  logic [PW-1:0]   pick_idx;
  logic            pick_valid;
  logic [NW-1:0]   pick_n;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .req    (bus.req),
    .ptr    (ptr_q),
    .gnt_oh (pick_oh),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  assign pick_n = bus.req_n[pick_idx*NW +: NW];

  // FSM next-state, operand/result capture, watchdog and rotation pointer
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    result_d = result_q;
    err_d    = 1'b0;
    eng_n_d  = eng_n_q;
    eng_st_d = 1'b0;
    wd_d     = wd_q;

    case (state_q)
      ST_IDLE: begin
        // an engine still busy (it has no reset) blocks any new grant
        if (pick_valid && !bus.eng_busy) begin
          owner_d  = pick_idx;
          gnt_d    = pick_oh;
          eng_n_d  = pick_n;
          eng_st_d = 1'b1;
          state_d  = ST_LAUNCH;
        end
      end

      ST_LAUNCH: begin
        wd_d    = '0;
        state_d = ST_WAIT_BUSY;
      end

      ST_WAIT_BUSY: begin
        if (bus.eng_busy) begin
          wd_d    = '0;
          state_d = ST_RUN;
        end else if (wd_q == WW'(WB_LIMIT - 1)) begin
          result_d = '0;
          err_d    = 1'b1;
          done_d   = gnt_q;
          state_d  = ST_DONE;
        end else begin
          wd_d = wd_q + WW'(1);
        end
      end

      ST_RUN: begin
        if (!bus.eng_busy) begin
          result_d = bus.eng_fn;
          done_d   = gnt_q;
          state_d  = ST_DONE;
        end else if (wd_q == WW'(TMO - 1)) begin
          result_d = '0;
          err_d    = 1'b1;
          done_d   = gnt_q;
          state_d  = ST_DONE;
        end else begin
          wd_d = wd_q + WW'(1);
        end
      end

      ST_DONE: begin
        // owner drops to lowest priority for the next round
        ptr_d   = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + PW'(1);
        gnt_d   = '0;
        state_d = ST_IDLE;
      end

      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      ptr_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      eng_n_q  <= '0;
      eng_st_q <= 1'b0;
      wd_q     <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      result_q <= result_d;
      err_q    <= err_d;
      eng_n_q  <= eng_n_d;
      eng_st_q <= eng_st_d;
      wd_q     <= wd_d;
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.err    = err_q;
  assign bus.eng_n  = eng_n_q;
  assign bus.eng_st = eng_st_q;

endmodule : fib_rr_scheduler
`default_nettype wire

// File: tb/tb_fib_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_fib_rr_scheduler
// Description : Directed self-checking bench for fib_rr_scheduler with a
//               behavioural iterative Fibonacci engine and stub modes
//               (never busy / busy stuck high).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fib_rr_scheduler;

  localparam int NREQ = 4;
  localparam int NW   = 8;
  localparam int FW   = 32;
  localparam int TMO  = 512;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  fib_rr_scheduler_if #(.NREQ(NREQ), .NW(NW), .FW(FW)) bus ();

  fib_rr_scheduler #(
    .NREQ (NREQ),
    .NW   (NW),
    .FW   (FW),
    .TMO  (TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // Engine: 0 = real iterative engine, 1 = busy never rises, 2 = busy sticks after start
  int            eng_mode  = 0;
  logic          eng_busy_r = 1'b0;
  logic [FW-1:0] eng_a     = '0;
  logic [FW-1:0] eng_b     = '0;
  logic [FW-1:0] eng_fn_r  = '0;
  logic [NW-1:0] eng_cnt   = '0;

  always @(posedge clk) begin
    case (eng_mode)
      0: begin
        if (!eng_busy_r) begin
          if (bus.eng_st) begin
            eng_busy_r <= 1'b1;
            eng_a      <= '0;
            eng_b      <= 32'd1;
            eng_cnt    <= bus.eng_n;
          end
        end else if (eng_cnt == 0) begin
          eng_busy_r <= 1'b0;
          eng_fn_r   <= eng_a;
        end else begin
          eng_a   <= eng_b;
          eng_b   <= eng_a + eng_b;
          eng_cnt <= eng_cnt - 1'b1;
        end
      end
      1:       eng_busy_r <= 1'b0;
      default: eng_busy_r <= eng_busy_r | bus.eng_st;
    endcase
  end

  assign bus.eng_busy = eng_busy_r;
  assign bus.eng_fn   = eng_fn_r;

  // Event counters
  int st_cnt   = 0;
  int done_cnt = 0;
  always @(posedge clk) begin
    if (bus.eng_st) st_cnt <= st_cnt + 1;
    if (|bus.done)  done_cnt <= done_cnt + 1;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_n(input int idx, input int n);
    bus.req_n[idx*NW +: NW] = NW'(n);
  endtask

  // cyc = edges until done is seen, -1 if the budget expires
  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    while (cyc < budget) begin
      tick(1);
      cyc++;
      if (|bus.done) return;
    end
    cyc = -1;
  endtask

  task automatic do_op(input string tag, input int idx, input int n,
                       input logic [FW-1:0] exp_res, input logic exp_err,
                       input int lo, input int hi);
    int cyc;
    int st0;
    st0 = st_cnt;
    bus.req[idx] = 1'b1;
    set_n(idx, n);
    wait_done(hi + 4, cyc);
    check({tag, "/done_seen"}, 64'(cyc >= 0), 1);
    check({tag, "/latency_ok"}, 64'(cyc >= lo && cyc <= hi), 1);
    check({tag, "/done"}, 64'(bus.done), 64'(1 << idx));
    check({tag, "/gnt"}, 64'(bus.gnt), 64'(1 << idx));
    check({tag, "/result"}, 64'(bus.result), 64'(exp_res));
    check({tag, "/err"}, 64'(bus.err), 64'(exp_err));
    bus.req[idx] = 1'b0;
    tick(1);
    check({tag, "/done_pulse_end"}, 64'({bus.done, bus.err}), 0);
    check({tag, "/st_pulses"}, 64'(st_cnt - st0), 1);
  endtask

  initial begin
    int cyc;
    int exp_idx;
    int d0;
    int viol;
    int guard;
    int st0;
    logic [FW-1:0] exp3 [4];
    exp3 = '{32'd2, 32'd3, 32'd5, 32'd8};

    bus.req   = '0;
    bus.req_n = '0;
    rst = 1'b1;
    tick(3);
    check("reset/gnt",    64'(bus.gnt), 0);
    check("reset/done",   64'(bus.done), 0);
    check("reset/err",    64'(bus.err), 0);
    check("reset/result", 64'(bus.result), 0);
    check("reset/eng_st", 64'(bus.eng_st), 0);
    check("reset/eng_n",  64'(bus.eng_n), 0);
    rst = 1'b0;
    tick(1);

    // single request, n=10
    do_op("t1_n10", 0, 10, 32'd55, 1'b0, 13, 18);

    // boundary operands on req[1]
    do_op("t2_n0",  1, 0,  32'd0,          1'b0, 3,  8);
    do_op("t2_n1",  1, 1,  32'd1,          1'b0, 4,  9);
    do_op("t2_n47", 1, 47, 32'd2971215073, 1'b0, 50, 55);
    do_op("t2_n48", 1, 48, 32'd512559680,  1'b0, 51, 56);

    // all four requesting: strict rotation from pointer 0
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_n(i, i + 3);
    bus.req = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      exp_idx = k % NREQ;
      wait_done(30, cyc);
      check($sformatf("t3_op%0d/done", k), 64'(bus.done), 64'(1 << exp_idx));
      check($sformatf("t3_op%0d/result", k), 64'(bus.result), 64'(exp3[exp_idx]));
      if (k == 5) bus.req = '0;
    end
    tick(3);
    check("t3/idle_gnt", 64'(bus.gnt), 0);

    // req[2] dropped and operand changed mid-operation
    st0 = st_cnt;
    bus.req[2] = 1'b1;
    set_n(2, 12);
    tick(5);
    check("t6/gnt", 64'(bus.gnt), 64'(4'b0100));
    bus.req[2] = 1'b0;
    set_n(2, 3);
    wait_done(30, cyc);
    check("t6/done", 64'(bus.done), 64'(4'b0100));
    check("t6/result", 64'(bus.result), 64'(32'd144));
    tick(6);
    check("t6/no_regrant", 64'(bus.gnt), 0);
    check("t6/st_pulses", 64'(st_cnt - st0), 1);

    // reset three cycles into RUN, engine keeps running
    bus.req[0] = 1'b1;
    set_n(0, 20);
    tick(6);
    d0 = done_cnt;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("t4/gnt",    64'(bus.gnt), 0);
    check("t4/done",   64'(bus.done), 0);
    check("t4/err",    64'(bus.err), 0);
    check("t4/result", 64'(bus.result), 0);
    check("t4/eng_st", 64'(bus.eng_st), 0);
    check("t4/eng_n",  64'(bus.eng_n), 0);
    check("t4/eng_still_busy", 64'(bus.eng_busy), 1);
    viol  = 0;
    guard = 0;
    while (bus.eng_busy && guard < 100) begin
      if (bus.gnt != 0) viol++;
      tick(1);
      guard++;
    end
    check("t4/engine_released", 64'(bus.eng_busy), 0);
    check("t4/no_gnt_while_busy", 64'(viol), 0);
    check("t4/no_done_aborted", 64'(done_cnt - d0), 0);
    wait_done(40, cyc);
    check("t4/regrant_done", 64'(bus.done), 64'(4'b0001));
    check("t4/regrant_result", 64'(bus.result), 64'(32'd6765));
    bus.req[0] = 1'b0;
    tick(2);

    // stub engines: no busy -> WAIT_BUSY abort; busy stuck -> watchdog abort
    eng_mode = 1;
    tick(1);
    do_op("t5_nobusy", 1, 5, 32'd0, 1'b1, 6, 6);
    eng_mode = 2;
    do_op("t5_stuck", 3, 5, 32'd0, 1'b1, TMO + 1, TMO + 6);
    eng_mode = 1;
    tick(3);
    eng_mode = 0;
    tick(1);
    do_op("t5_recover", 2, 7, 32'd13, 1'b0, 10, 15);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_fib_rr_scheduler
`default_nettype wire
